mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the address and data width.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of cycles to wait for a memory response (range 2..255).
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port if_req, input, 1, fetch request; held until if_gnt.
REQ-006 The block SHALL have port if_addr, input, WIDTH, fetch address.
REQ-007 The block SHALL have port if_gnt, output, 1, fetch request accepted.
REQ-008 The block SHALL have port if_rvalid, output, 1, fetch response valid, one-cycle pulse.
REQ-009 The block SHALL have port if_rdata, output, WIDTH, fetch read data.
REQ-010 The block SHALL have port if_err, output, 1, fetch response is a timeout error.
REQ-011 The block SHALL have port d_req, input, 1, data request; held until d_gnt.
REQ-012 The block SHALL have port d_we, input, 1, data write enable.
REQ-013 The block SHALL have port d_addr, input, WIDTH, data address.
REQ-014 The block SHALL have port d_wdata, input, WIDTH, data write data.
REQ-015 The block SHALL have port d_gnt, output, 1, data request accepted.
REQ-016 The block SHALL have port d_rvalid, output, 1, data response valid (read data or write ack), one-cycle pulse.
REQ-017 The block SHALL have port d_rdata, output, WIDTH, data read data.
REQ-018 The block SHALL have port d_err, output, 1, data response is a timeout error.
REQ-019 The block SHALL have port mem_req, output, 1, request to the shared memory.
REQ-020 The block SHALL have port mem_we, output, 1, memory write enable.
REQ-021 The block SHALL have port mem_addr, output, WIDTH, memory address.
REQ-022 The block SHALL have port mem_wdata, output, WIDTH, memory write data.
REQ-023 The block SHALL have port mem_gnt, input, 1, memory accepts mem_req this cycle.
REQ-024 The block SHALL have port mem_rvalid, input, 1, memory response valid.
REQ-025 The block SHALL have port mem_rdata, input, WIDTH, memory read data.

Function
REQ-026 The FSM SHALL have states IDLE, REQ and RESP, with at most one transaction outstanding.
REQ-027 In IDLE, when any request is present, the block SHALL:
- pick the owner;
- pulse the owner's gnt combinationally that cycle;
- latch owner, we, addr and wdata into registers;
- enter REQ on the next edge.
For fetch, the latched we and wdata SHALL be 0.
REQ-028 Owner selection SHALL be round-robin. With a single requester, that requester wins. With both requesting, the requester not served last wins. The last-owner register SHALL be reset to fetch, so data wins the first tie.
REQ-029 In REQ, the block SHALL drive mem_req=1 from the latched fields, holding them stable until mem_gnt=1, then enter RESP and clear the timeout counter.
REQ-030 In RESP, mem_req SHALL be 0. On mem_rvalid=1, the block SHALL register mem_rdata to the owner's rdata, pulse the owner's rvalid in the next cycle with err=0, and return to IDLE.
REQ-031 Writes SHALL complete only on mem_rvalid, and the rdata value SHALL be don't-care for writes.
REQ-032 If RESP lasts TIMEOUT cycles without mem_rvalid, the block SHALL pulse the owner's rvalid=1 and err=1 with rdata=0 in the next cycle, and return to IDLE.
REQ-033 A mem_rvalid arriving while in IDLE or REQ SHALL be ignored.
REQ-034 mem_req, mem_we, mem_addr and mem_wdata SHALL be zero whenever the state is not REQ.
REQ-035 A request dropped before its gnt SHALL generate no transaction, and a gnt SHALL never be issued outside IDLE.
REQ-036 Minimum latency SHALL be: gnt at cycle 0, mem_req at cycle 1, and owner rvalid one cycle after mem_rvalid. A new arbitration SHALL occur no earlier than the cycle after returning to IDLE.
REQ-037 rvalid and err for the non-owner SHALL remain 0.

Reset
REQ-038 On any rising clk edge with rst=0, the block SHALL enter IDLE, set last-owner to fetch, and clear the counter and all latched fields, regardless of the current state.
REQ-039 While in reset, all outputs SHALL be 0, and an in-flight transaction SHALL be abandoned with no response to its requester.

Verification
REQ-040 Fetch read: if_req with if_addr=0x40 at cycle 0, mem_gnt at cycle 1, mem_rvalid with mem_rdata=0xDEADBEEF at cycle 3 -> if_gnt at cycle 0, mem_req only at cycle 1, if_rvalid with if_rdata=0xDEADBEEF and if_err=0 at cycle 4.
REQ-041 Tie after reset: if_req and d_req both asserted (d_we=1, d_addr=0x100, d_wdata=0x5A) -> d_gnt first with mem_we=1, mem_addr=0x100, mem_wdata=0x5A; if_gnt only at the next IDLE.
REQ-042 Both requesters continuously active with immediate mem_gnt and mem_rvalid -> grant order D, IF, D, IF, with no double grants.
REQ-043 mem_gnt held low for 5 cycles in REQ -> mem_req, mem_addr and mem_we stable for all 5 cycles; transaction proceeds on the 6th.
REQ-044 TIMEOUT=16 with no mem_rvalid -> owner rvalid=1, err=1, rdata=0 after 16 RESP cycles; a later mem_rvalid produces no pulse.
REQ-045 rst=0 for one cycle while in RESP -> the next cycle is IDLE with all outputs 0; a subsequent mem_rvalid is ignored; the next tie grants data.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and data requesters.
// Revision 1.0 -- one outstanding transaction, response timeout with error reply.
`default_nettype none

module mem_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic             if_gnt,
   output logic             if_rvalid,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_err,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic             d_gnt,
   output logic             d_rvalid,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_err,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic             owner_q, owner_d;   // 1 = data port owns the transaction
   logic             last_q, last_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             if_rv_q, if_rv_d;
   logic             d_rv_q, d_rv_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;

   logic pick_d;
   logic in_idle;
   logic in_req;

   // Data wins when it is alone, or on a tie when fetch was served last.
   assign pick_d  = d_req && (!if_req || !last_q);
   assign in_idle = rst && (state_q == S_IDLE);
   assign in_req  = rst && (state_q == S_REQ);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      if_rv_d = 1'b0;
      d_rv_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (if_req || d_req) begin
               owner_d = pick_d;
               last_d  = pick_d;
               we_d    = pick_d & d_we;
               addr_d  = pick_d ? d_addr : if_addr;
               wdata_d = pick_d ? d_wdata : '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               cnt_d   = '0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (mem_rvalid) begin
               if_rv_d = !owner_q;
               d_rv_d  = owner_q;
               rdata_d = mem_rdata;
               state_d = S_IDLE;
            end else if (cnt_q == C_CNT_LAST) begin
               if_rv_d = !owner_q;
               d_rv_d  = owner_q;
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         if_rv_q <= 1'b0;
         d_rv_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         if_rv_q <= if_rv_d;
         d_rv_q  <= d_rv_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Every output is forced low while reset is held, even mid-transaction.
   assign if_gnt    = in_idle && if_req && !pick_d;
   assign d_gnt     = in_idle && pick_d;
   assign mem_req   = in_req;
   assign mem_we    = in_req && we_q;
   assign mem_addr  = in_req ? addr_q : '0;
   assign mem_wdata = in_req ? wdata_q : '0;

   assign if_rvalid = rst && if_rv_q;
   assign if_err    = rst && if_rv_q && err_q;
   assign if_rdata  = (rst && if_rv_q) ? rdata_q : '0;
   assign d_rvalid  = rst && d_rv_q;
   assign d_err     = rst && d_rv_q && err_q;
   assign d_rdata   = (rst && d_rv_q) ? rdata_q : '0;

endmodule

`default_nettype wire
